alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised-width successor to the 8-bit combinational ALU, with registered outputs and valid/ready handshakes on input and output.
- Adds ADC, SBB, ASR, ROL/ROR, an iterative multi-cycle MUL, and a full flag set: carry, zero, negative, overflow, error.
- Sits between the operand/decode logic and the writeback path; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits. Power of 2, minimum 4.
- SHW, $clog2(WIDTH), shift-amount width taken from i_b[SHW-1:0]. Derived; do not override.

Ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_valid  in  1  operand/op valid
- o_ready  out  1  block can accept an operation this cycle
- i_a  in  WIDTH  operand A
- i_b  in  WIDTH  operand B; also the shift/rotate amount
- i_op  in  4  opcode
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts the result
- o_res  out  WIDTH  result
- o_carry  out  1  carry/borrow flag
- o_zero  out  1  o_res == 0
- o_neg  out  1  o_res[WIDTH-1]
- o_ovf  out  1  signed overflow
- o_err  out  1  illegal opcode

Behaviour:
- Reset (asynchronous, active-low): o_valid=0, o_res=0, all flags=0, internal carry flag=0, state=IDLE. o_ready=1 once reset is released. Reset during BUSY aborts the MUL; the result is discarded.
- Handshake:
  - Accept occurs on a rising edge with i_valid && o_ready.
  - Output transfer occurs on a rising edge with o_valid && i_ready.
  - o_ready = (state==IDLE) && (!o_valid || i_ready), so a new result may load on the same edge the old one is taken.
  - While o_valid && !i_ready, o_res and all flags hold stable.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(A).
  - 6 SHR (logical), 7 SHL, 8 ASR, 9 ROL, A ROR. Shift/rotate amount = i_b[SHW-1:0].
  - B ADC: A+B+Cf. C SBB: A-B-Cf. Cf is the internal carry flag.
  - D MUL: unsigned, low WIDTH bits returned.
  - E, F illegal.
- Latency: all ops except MUL produce o_valid in the cycle after accept (1 cycle). Sustained throughput is 1 op/cycle while i_ready=1.
- MUL state machine, states IDLE and BUSY:
  - Accept of MUL moves IDLE->BUSY and loads the operands and iteration counter = WIDTH.
  - BUSY performs one shift-add iteration per cycle, WIDTH cycles total, with o_ready=0 throughout.
  - On the final iteration the result is written to the output regs, o_valid goes high and the state returns to IDLE.
  - Total latency is WIDTH+1 cycles from accept to o_valid. MUL is never accepted while o_valid is held by backpressure.
- Flags:
  - ADD/ADC: carry = carry-out; ovf = operand signs equal && result sign differs.
  - SUB/SBB: carry = borrow (1 when A < B+borrow-in, unsigned); ovf = operand signs differ && result sign != sign of A.
  - MUL: carry = upper WIDTH bits of the full product nonzero; ovf=0.
  - Logic ops: carry=0, ovf=0.
  - Shifts/rotates: carry = last bit shifted or rotated out, 0 when amount=0; ovf=0.
  - zero and neg are computed from o_res for every op.
- Internal carry flag Cf updates to o_carry on every accepted legal op. Illegal ops leave Cf unchanged.
- Illegal opcode: o_res=0, o_err=1, other flags 0, latency 1. o_err=0 for all legal ops.
- Widths: all arithmetic is modulo 2^WIDTH. The shift amount ignores i_b bits at SHW and above.

Test Plan (WIDTH=8 unless noted):
- ADD A=0x0F B=0x01 -> o_res=0x10, c=0 z=0 n=0 v=0, o_valid high 1 cycle after accept. ADD 0xFF+0x01 -> 0x00, c=1 z=1. ADD 0x7F+0x01 -> 0x80, n=1 v=1.
- SUB 0x01-0x02 -> 0xFF, c=1 n=1 v=0. Then ADC 0x00+0x00 -> 0x01 (Cf=1). Then SBB 0x05-0x01 with Cf=0 -> 0x04.
- SHR 0x0F by 2 -> 0x03, c=1. SHL 0x0F by 2 -> 0x3C, c=0. ASR 0x80 by 3 -> 0xF0. ROL 0x81 by 1 -> 0x03, c=1. B=0x0A acts as shift 2.
- MUL 0x10*0x12 -> 0x20, c=1; o_ready low for 8 cycles; o_valid exactly 9 cycles after accept. MUL 0x05*0x03 -> 0x0F, c=0.
- Backpressure:
  - i_ready=0 for 5 cycles after a result -> o_res and flags stable, o_ready=0, no accept.
  - Releasing i_ready with i_valid high transfers the held result and accepts the next op on the same edge.
  - 10 back-to-back ADDs with i_ready=1 -> 10 results in 10 consecutive cycles.
- Reset mid-MUL (i_rstn low at BUSY cycle 4) -> o_valid=0 and outputs 0 immediately. After release, o_ready=1 and a fresh ADD completes normally. Opcode 0xF -> o_res=0, o_err=1. Repeat the ADD/MUL cases at WIDTH=16 (MUL latency 17).

Source files
------------

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: operation request side plus
// registered result and flags.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [3:0]       i_op;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_res;
    logic             o_carry;
    logic             o_zero;
    logic             o_neg;
    logic             o_ovf;
    logic             o_err;

    modport master (
        output i_valid, i_a, i_b, i_op, i_ready,
        input  o_ready, o_valid, o_res, o_carry, o_zero, o_neg, o_ovf, o_err
    );

    modport slave (
        input  i_valid, i_a, i_b, i_op, i_ready,
        output o_ready, o_valid, o_res, o_carry, o_zero, o_neg, o_ovf, o_err
    );
endinterface

// File: rtl/alu_pipe.sv
// Parametrised ALU with registered result/flags, valid/ready handshakes and an
// iterative shift-add multiplier; one operation in flight at a time.
module alu_pipe #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic      i_clk,
    input  logic      i_rstn,
    alu_pipe_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                           OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHR = 4'h6, OP_SHL = 4'h7,
                           OP_ASR = 4'h8, OP_ROL = 4'h9, OP_ROR = 4'hA, OP_ADC = 4'hB,
                           OP_SBB = 4'hC, OP_MUL = 4'hD;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
    logic                 ovf_q, ovf_d, err_q, err_d, cf_q, cf_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [WIDTH-1:0]     a, b, alu_res;
    logic [SHW-1:0]       sh;
    logic                 cin, alu_c, alu_v, alu_err, ready, accept;
    logic [WIDTH:0]       sum_w, dif_w;
    logic [2*WIDTH-1:0]   shr_w, shl_w, acc_next;
    logic signed [2*WIDTH-1:0] asr_w;

    // Shifts run over a 2*WIDTH window so the last bit shifted out lands at a
    // fixed position, which also yields carry=0 for a zero shift amount.
    always_comb begin
        a       = bus.i_a;
        b       = bus.i_b;
        sh      = bus.i_b[SHW-1:0];
        cin     = (bus.i_op == OP_ADC || bus.i_op == OP_SBB) ? cf_q : 1'b0;
        sum_w   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        dif_w   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        shr_w   = {a, {WIDTH{1'b0}}} >> sh;
        shl_w   = {{WIDTH{1'b0}}, a} << sh;
        asr_w   = $signed({a, {WIDTH{1'b0}}}) >>> sh;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (bus.i_op)
            OP_ADD, OP_ADC: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                alu_res = dif_w[WIDTH-1:0];
                alu_c   = dif_w[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHR: begin
                alu_res = shr_w[2*WIDTH-1:WIDTH];
                alu_c   = shr_w[WIDTH-1];
            end
            OP_SHL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            OP_ASR: begin
                alu_res = asr_w[2*WIDTH-1:WIDTH];
                alu_c   = asr_w[WIDTH-1];
            end
            OP_ROL: begin
                alu_res = shl_w[WIDTH-1:0] | shl_w[2*WIDTH-1:WIDTH];
                alu_c   = shl_w[WIDTH];
            end
            OP_ROR: begin
                alu_res = shr_w[2*WIDTH-1:WIDTH] | shr_w[WIDTH-1:0];
                alu_c   = shr_w[WIDTH-1];
            end
            OP_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // Handshake, result load and the MUL iteration state machine.
    always_comb begin
        ready    = (state_q == IDLE) && (!valid_q || bus.i_ready);
        accept   = bus.i_valid && ready;
        acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;
        state_d  = state_q;
        valid_d  = valid_q;
        res_d    = res_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        cf_d     = cf_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (valid_q && bus.i_ready) valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && bus.i_op == OP_MUL) begin
                    state_d  = BUSY;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    cnt_d    = CW'(WIDTH);
                end else if (accept) begin
                    valid_d = 1'b1;
                    res_d   = alu_res;
                    carry_d = alu_c;
                    zero_d  = !alu_err && (alu_res == '0);
                    neg_d   = alu_res[WIDTH-1];
                    ovf_d   = alu_v;
                    err_d   = alu_err;
                    if (!alu_err) cf_d = alu_c;
                end
            end
            BUSY: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    res_d   = acc_next[WIDTH-1:0];
                    carry_d = |acc_next[2*WIDTH-1:WIDTH];
                    zero_d  = (acc_next[WIDTH-1:0] == '0);
                    neg_d   = acc_next[WIDTH-1];
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    cf_d    = |acc_next[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            cf_q     <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            cf_q     <= cf_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = valid_q;
    assign bus.o_res   = res_q;
    assign bus.o_carry = carry_q;
    assign bus.o_zero  = zero_q;
    assign bus.o_neg   = neg_q;
    assign bus.o_ovf   = ovf_q;
    assign bus.o_err   = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8 and WIDTH=16: opcode table with
// hand-computed results/flags/latency, backpressure, back-to-back and reset cases.
module tb_alu_pipe;
    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   xfer8 = 0;
    int   xfer_before;
    logic [15:0] got_res;
    logic [4:0]  got_fl;
    int          got_lat, got_busy;
    vec_t        v8[$];
    vec_t        v16[$];

    alu_pipe_if #(.WIDTH(8))  if8();
    alu_pipe_if #(.WIDTH(16)) if16();

    alu_pipe #(.WIDTH(8))  dut8 (.i_clk(clk), .i_rstn(rstn), .bus(if8));
    alu_pipe #(.WIDTH(16)) dut16(.i_clk(clk), .i_rstn(rstn), .bus(if16));

    always #5 clk = ~clk;

    always @(posedge clk) if (if8.o_valid && if8.i_ready) xfer8 <= xfer8 + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        if8.i_op = op; if8.i_a = a; if8.i_b = b; if8.i_valid = 1'b1; if8.i_ready = 1'b1;
        while (!if8.o_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        if8.i_valid = 1'b0;
        got_lat = 1; got_busy = 0;
        while (!if8.o_valid && got_lat < 200) begin
            if (!if8.o_ready) got_busy++;
            @(posedge clk); #1;
            got_lat++;
        end
        got_res = {8'h00, if8.o_res};
        got_fl  = {if8.o_carry, if8.o_zero, if8.o_neg, if8.o_ovf, if8.o_err};
    endtask

    task automatic applyStimulus16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        @(negedge clk);
        if16.i_op = op; if16.i_a = a; if16.i_b = b; if16.i_valid = 1'b1; if16.i_ready = 1'b1;
        while (!if16.o_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        if16.i_valid = 1'b0;
        got_lat = 1; got_busy = 0;
        while (!if16.o_valid && got_lat < 200) begin
            if (!if16.o_ready) got_busy++;
            @(posedge clk); #1;
            got_lat++;
        end
        got_res = if16.o_res;
        got_fl  = {if16.o_carry, if16.o_zero, if16.o_neg, if16.o_ovf, if16.o_err};
    endtask

    initial begin
        // flags packed as {carry, zero, neg, ovf, err}; order matters because of Cf
        v8.push_back('{4'h0, 16'h0F, 16'h01, 16'h10, 5'b00000, 1});
        v8.push_back('{4'h0, 16'hFF, 16'h01, 16'h00, 5'b11000, 1});
        v8.push_back('{4'h0, 16'h7F, 16'h01, 16'h80, 5'b00110, 1});
        v8.push_back('{4'h1, 16'h01, 16'h02, 16'hFF, 5'b10100, 1});
        v8.push_back('{4'hB, 16'h00, 16'h00, 16'h01, 5'b00000, 1});
        v8.push_back('{4'hC, 16'h05, 16'h01, 16'h04, 5'b00000, 1});
        v8.push_back('{4'h1, 16'h80, 16'h01, 16'h7F, 5'b00010, 1});
        v8.push_back('{4'h1, 16'h00, 16'h01, 16'hFF, 5'b10100, 1});
        v8.push_back('{4'hC, 16'h10, 16'h05, 16'h0A, 5'b00000, 1});
        v8.push_back('{4'h2, 16'hF0, 16'h3C, 16'h30, 5'b00000, 1});
        v8.push_back('{4'h3, 16'hF0, 16'h0F, 16'hFF, 5'b00100, 1});
        v8.push_back('{4'h4, 16'hAA, 16'hAA, 16'h00, 5'b01000, 1});
        v8.push_back('{4'h5, 16'h0F, 16'h00, 16'hF0, 5'b00100, 1});
        v8.push_back('{4'h6, 16'h0F, 16'h02, 16'h03, 5'b10000, 1});
        v8.push_back('{4'h7, 16'h0F, 16'h02, 16'h3C, 5'b00000, 1});
        v8.push_back('{4'h8, 16'h80, 16'h03, 16'hF0, 5'b00100, 1});
        v8.push_back('{4'h9, 16'h81, 16'h01, 16'h03, 5'b10000, 1});
        v8.push_back('{4'hA, 16'h81, 16'h01, 16'hC0, 5'b10100, 1});
        v8.push_back('{4'h6, 16'h0F, 16'h0A, 16'h03, 5'b10000, 1});
        v8.push_back('{4'h7, 16'h80, 16'h00, 16'h80, 5'b00100, 1});
        v8.push_back('{4'hD, 16'h10, 16'h12, 16'h20, 5'b10000, 9});
        v8.push_back('{4'hF, 16'h12, 16'h34, 16'h00, 5'b00001, 1});
        v8.push_back('{4'hE, 16'h01, 16'h01, 16'h00, 5'b00001, 1});
        v8.push_back('{4'hB, 16'h00, 16'h00, 16'h01, 5'b00000, 1});
        v8.push_back('{4'hD, 16'h05, 16'h03, 16'h0F, 5'b00000, 9});

        v16.push_back('{4'h0, 16'h00FF, 16'h0001, 16'h0100, 5'b00000, 1});
        v16.push_back('{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 5'b11000, 1});
        v16.push_back('{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 5'b00110, 1});
        v16.push_back('{4'hD, 16'h0100, 16'h0100, 16'h0000, 5'b11000, 17});
        v16.push_back('{4'hD, 16'h0123, 16'h0011, 16'h1353, 5'b00000, 17});
        v16.push_back('{4'h9, 16'h8001, 16'h0011, 16'h0003, 5'b10000, 1});
        v16.push_back('{4'hF, 16'h1234, 16'h5678, 16'h0000, 5'b00001, 1});

        if8.i_valid = 1'b0; if8.i_ready = 1'b1; if8.i_op = 4'h0; if8.i_a = '0; if8.i_b = '0;
        if16.i_valid = 1'b0; if16.i_ready = 1'b1; if16.i_op = 4'h0; if16.i_a = '0; if16.i_b = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset outputs", {if8.o_valid, if8.o_res, if8.o_carry, if8.o_zero,
                    if8.o_neg, if8.o_ovf, if8.o_err}, 32'h0);
        rstn = 1'b1;
        #1 checkOutput("reset ready", {31'h0, if8.o_ready}, 32'h1);

        foreach (v8[i]) begin
            applyStimulus8(v8[i].op, v8[i].a[7:0], v8[i].b[7:0]);
            checkOutput($sformatf("w8 vec%0d res", i), {16'h0, got_res}, {16'h0, v8[i].res});
            checkOutput($sformatf("w8 vec%0d flags", i), {27'h0, got_fl}, {27'h0, v8[i].fl});
            checkOutput($sformatf("w8 vec%0d latency", i), got_lat, v8[i].lat);
            checkOutput($sformatf("w8 vec%0d ready-low", i), got_busy, v8[i].lat - 1);
        end

        // Backpressure: hold a result for 5 cycles with the next op waiting
        @(negedge clk); if8.i_valid = 1'b0; if8.i_ready = 1'b1;
        @(negedge clk);
        if8.i_op = 4'h0; if8.i_a = 8'h22; if8.i_b = 8'h11; if8.i_valid = 1'b1; if8.i_ready = 1'b0;
        @(posedge clk); #1;
        if8.i_op = 4'h1; if8.i_a = 8'h50; if8.i_b = 8'h10;
        xfer_before = xfer8;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp hold", {if8.o_valid, if8.o_ready, if8.o_res, if8.o_carry, if8.o_zero,
                        if8.o_neg, if8.o_ovf, if8.o_err}, {17'h0, 1'b1, 1'b0, 8'h33, 5'b00000});
        end
        if8.i_ready = 1'b1;
        #1 checkOutput("bp release ready", {31'h0, if8.o_ready}, 32'h1);
        @(posedge clk); #1;
        checkOutput("bp next result", {if8.o_valid, if8.o_res, if8.o_carry, if8.o_zero,
                    if8.o_neg, if8.o_ovf, if8.o_err}, {18'h0, 1'b1, 8'h40, 5'b00000});
        checkOutput("bp transfers", xfer8 - xfer_before, 1);
        if8.i_valid = 1'b0;

        // Back-to-back: ten ADDs, one result per cycle
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i > 0)
                checkOutput($sformatf("b2b %0d", i - 1), {23'h0, if8.o_valid, if8.o_res},
                            {23'h0, 1'b1, 8'(i - 1 + 16'h10)});
            if (i < 10) begin
                checkOutput($sformatf("b2b ready %0d", i), {31'h0, if8.o_ready}, 32'h1);
                if8.i_op = 4'h0; if8.i_a = 8'(i); if8.i_b = 8'h10; if8.i_valid = 1'b1;
            end else begin
                if8.i_valid = 1'b0;
            end
        end

        // Reset during BUSY cycle 4 of a MUL
        @(negedge clk);
        if8.i_op = 4'hD; if8.i_a = 8'h10; if8.i_b = 8'h12; if8.i_valid = 1'b1; if8.i_ready = 1'b1;
        @(posedge clk); #1;
        if8.i_valid = 1'b0;
        checkOutput("mul busy ready", {31'h0, if8.o_ready}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk); rstn = 1'b0;
        #1 checkOutput("rst mid-mul outputs", {if8.o_valid, if8.o_res, if8.o_carry, if8.o_zero,
                       if8.o_neg, if8.o_ovf, if8.o_err}, 32'h0);
        @(negedge clk); rstn = 1'b1;
        #1 checkOutput("rst release ready", {31'h0, if8.o_ready}, 32'h1);
        repeat (12) @(negedge clk);
        checkOutput("rst mul discarded", {31'h0, if8.o_valid}, 32'h0);
        applyStimulus8(4'hB, 8'h01, 8'h01);
        checkOutput("post-rst adc res", {16'h0, got_res}, 32'h02);
        applyStimulus8(4'h0, 8'h0F, 8'h01);
        checkOutput("post-rst add res", {16'h0, got_res}, 32'h10);
        checkOutput("post-rst add latency", got_lat, 1);

        foreach (v16[i]) begin
            applyStimulus16(v16[i].op, v16[i].a, v16[i].b);
            checkOutput($sformatf("w16 vec%0d res", i), {16'h0, got_res}, {16'h0, v16[i].res});
            checkOutput($sformatf("w16 vec%0d flags", i), {27'h0, got_fl}, {27'h0, v16[i].fl});
            checkOutput($sformatf("w16 vec%0d latency", i), got_lat, v16[i].lat);
            checkOutput($sformatf("w16 vec%0d ready-low", i), got_busy, v16[i].lat - 1);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
